mux16_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 16-bit 4-to-1 datapath mux between four requesters.
- Drives the mux SEL field and returns a one-hot grant to each requester.
- Enforces a maximum burst length so no requester holds the shared bus indefinitely.
- Sits between the four source units and the mux16_4to1 instance in the CPU datapath.

---
 rtl/mux16_rr_arbiter.sv | 68 ++++++
 tb/tb_mux16_rr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner of the shared 16-bit 4:1 mux with a burst-length cap
module mux16_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] SEL,
  output logic       BUSY
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0] nxt;
  logic rivals;
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] s);
    logic [1:0] idx;
    pick = s;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction
  always_comb begin
    rivals = |(REQ & ~(4'b0001 << SEL));
    nxt = pick(REQ, state == OWN ? SEL + 2'd1 : ptr);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      GNT <= '0;
      SEL <= '0;
      BUSY <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (|REQ) begin
        state <= OWN;
        GNT <= 4'b0001 << nxt;
        SEL <= nxt;
        BUSY <= 1'b1;
        cnt <= CNT_W'(1);
        ptr <= nxt;
      end
    end else if (!REQ[SEL] || cnt == CNT_W'(MAX_BURST)) begin
      // release or burst expiry: hand straight to the next requester when there is one
      if (rivals) begin
        GNT <= 4'b0001 << nxt;
        SEL <= nxt;
        cnt <= CNT_W'(1);
        ptr <= nxt;
      end else if (!REQ[SEL]) begin
        state <= IDLE;
        GNT <= '0;
        BUSY <= 1'b0;
        ptr <= SEL + 2'd1;
        cnt <= '0;
      end else begin
        cnt <= CNT_W'(1);
      end
    end else begin
      cnt <= cnt < CNT_W'(MAX_BURST) ? cnt + CNT_W'(1) : cnt;
    end
  end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and constrained-random checks of the round-robin mux arbiter
module tb_mux16_rr_arbiter;
  logic CLK, RST;
  logic [3:0] REQ, GNT;
  logic [1:0] SEL;
  logic BUSY;
  int vectors = 0;
  int miscompares = 0;

  mux16_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .SEL(SEL), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 4'b1111;
    tick();
    tick();
    vectors++;
    if ({GNT, SEL, BUSY} !== 7'b0000_00_0) begin
      miscompares++;
      $display("FAIL reset: got GNT=%b SEL=%0d BUSY=%b, expected 0000/0/0", GNT, SEL, BUSY);
    end
    REQ = 4'b0000;
    RST = 1'b0;
    tick();
    vectors++;
    if ({GNT, BUSY} !== 5'b0000_0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got GNT=%b BUSY=%b, expected 0000/0", GNT, BUSY);
    end
  endtask

  task automatic test_single();
    apply_reset();
    REQ = 4'b0100;
    tick();
    vectors++;
    if ({GNT, SEL, BUSY} !== {4'b0100, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL single_grant: got GNT=%b SEL=%0d BUSY=%b, expected 0100/2/1", GNT, SEL, BUSY);
    end
    REQ = 4'b0000;
    tick();
    vectors++;
    if ({GNT, SEL, BUSY} !== {4'b0000, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL single_release: got GNT=%b SEL=%0d BUSY=%b, expected 0000/2/0", GNT, SEL, BUSY);
    end
    REQ = 4'b1111;
    tick();
    vectors++;
    if (GNT !== 4'b1000) begin
      miscompares++;
      $display("FAIL ptr_after_release: got GNT=%b, expected 1000", GNT);
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    apply_reset();
    REQ = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = 4'b0001 << (i / 4);
      vectors++;
      if (GNT !== exp || SEL !== 2'(i / 4) || BUSY !== 1'b1) begin
        miscompares++;
        $display("FAIL rotation[%0d]: got GNT=%b SEL=%0d BUSY=%b, expected %b/%0d/1", i, GNT, SEL, BUSY, exp, i / 4);
      end
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_handoff();
    logic [3:0] exp;
    apply_reset();
    REQ = 4'b0010;
    tick();
    REQ = 4'b1001;
    tick();
    vectors++;
    if ({GNT, SEL} !== {4'b1000, 2'd3}) begin
      miscompares++;
      $display("FAIL handoff: got GNT=%b SEL=%0d, expected 1000/3", GNT, SEL);
    end
    // a fresh burst of 4 for owner 3, then expiry passes to pick(0)
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = i < 3 ? 4'b1000 : 4'b0001;
      vectors++;
      if (GNT !== exp) begin
        miscompares++;
        $display("FAIL handoff_burst[%0d]: got GNT=%b, expected %b", i, GNT, exp);
      end
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_solo_burst();
    apply_reset();
    REQ = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({GNT, SEL, BUSY} !== {4'b0100, 2'd2, 1'b1}) begin
        miscompares++;
        $display("FAIL solo[%0d]: got GNT=%b SEL=%0d BUSY=%b, expected 0100/2/1", i, GNT, SEL, BUSY);
      end
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    REQ = 4'b1000;
    tick();
    tick();
    RST = 1'b1;
    tick();
    vectors++;
    if ({GNT, SEL, BUSY} !== 7'b0000_00_0) begin
      miscompares++;
      $display("FAIL mid_reset: got GNT=%b SEL=%0d BUSY=%b, expected 0000/0/0", GNT, SEL, BUSY);
    end
    RST = 1'b0;
    tick();
    vectors++;
    if ({GNT, SEL, BUSY} !== {4'b1000, 2'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_grant: got GNT=%b SEL=%0d BUSY=%b, expected 1000/3/1", GNT, SEL, BUSY);
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    int wait_cnt [4];
    logic [15:0] d [4];
    logic [15:0] mux_y;
    logic [3:0] r;
    int idx;
    apply_reset();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    REQ = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      r = REQ;
      tick();
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      mux_y = d[SEL];
      idx = 0;
      for (int i = 0; i < 4; i++) if (GNT[i]) idx = i;
      vectors++;
      if (!$onehot0(GNT) || ((GNT != 4'b0000) !== BUSY) || (BUSY && (GNT !== 4'b0001 << SEL || mux_y !== d[idx]))) begin
        miscompares++;
        $display("FAIL rand_invariant[%0d]: got GNT=%b SEL=%0d BUSY=%b, expected one-hot GNT matching SEL and BUSY", c, GNT, SEL, BUSY);
      end
      for (int i = 0; i < 4; i++) begin
        wait_cnt[i] = (r[i] && !GNT[i]) ? wait_cnt[i] + 1 : 0;
        vectors++;
        if (wait_cnt[i] > 12) begin
          miscompares++;
          $display("FAIL rand_wait[%0d] req%0d: got wait %0d, expected <= 12", c, i, wait_cnt[i]);
          wait_cnt[i] = 0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (r[i] && GNT[i] && $urandom_range(3) == 0) r[i] = 1'b0;
        else if (!r[i] && $urandom_range(2) == 0) r[i] = 1'b1;
      end
      REQ = r;
    end
    REQ = 4'b0000;
    tick();
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_handoff();
    test_solo_burst();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
